// File: rtl/ppwm_ctrl.sv
// ppwm_ctrl: period sequencer and program store for the programmable-PWM execution unit.
//
// Owns the instruction memory, generates the global period counter and the per-period
// start pulse, holds the execution unit in reset while idle (so programs are loaded
// safely and every run restarts at pc 0), and registers the final PWM pin.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   enable_i              level-sensitive run request
//   prescale_i            counter advances every prescale_i+1 cycles (sampled per period)
//   wr_valid_i/wr_ready_o program write handshake (accepted only while idle)
//   wr_addr_i, wr_data_i  program write address / data
//   pc_i, instr_o         combinational instruction fetch for the execution unit
//   pwm_value_i           PWM compare value from the execution unit
//   ex_rst_no             synchronous active-low reset to the execution unit
//   start_o               one-cycle period-start pulse
//   global_counter_o      global period counter
//   running_o             high while running or stopping
//   pwm_o                 PWM pin
module ppwm_ctrl #(
    parameter int unsigned COUNTER_WIDTH  = 10,
    parameter int unsigned INSTR_WIDTH    = 7,
    parameter int unsigned PC_WIDTH       = 4,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [PC_WIDTH-1:0]       wr_addr_i,
    input  logic [INSTR_WIDTH-1:0]    wr_data_i,
    input  logic [PC_WIDTH-1:0]       pc_i,
    output logic [INSTR_WIDTH-1:0]    instr_o,
    input  logic [COUNTER_WIDTH-1:0]  pwm_value_i,
    output logic                      ex_rst_no,
    output logic                      start_o,
    output logic [COUNTER_WIDTH-1:0]  global_counter_o,
    output logic                      running_o,
    output logic                      pwm_o
);

    localparam int unsigned Depth = 2 ** PC_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    state_e                    state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] psc_cnt_q, psc_cnt_d;
    logic [PRESCALE_WIDTH-1:0] psc_val_q, psc_val_d;
    logic                      start_q, start_d;
    logic                      ex_rst_n_q, ex_rst_n_d;
    logic                      running_q, running_d;
    logic                      pwm_q, pwm_d;
    logic [INSTR_WIDTH-1:0]    mem_q [Depth];

    logic tick;
    logic wrap;
    logic wr_en;

    assign wr_ready_o = (state_q == StIdle);
    assign wr_en      = wr_valid_i && wr_ready_o;
    assign instr_o    = mem_q[pc_i];

    assign tick = (state_q != StIdle) && (psc_cnt_q == psc_val_q);
    assign wrap = tick && (cnt_q == {COUNTER_WIDTH{1'b1}});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        psc_cnt_d = psc_cnt_q;
        psc_val_d = psc_val_q;
        start_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d     = '0;
                psc_cnt_d = '0;
                if (enable_i) begin
                    state_d   = StRun;
                    start_d   = 1'b1;
                    psc_val_d = prescale_i;
                end
            end
            StRun: begin
                if (!enable_i) begin
                    state_d = StStop;
                end
                // A wrap still starts a new period even if enable drops on that cycle.
                if (wrap) begin
                    start_d   = 1'b1;
                    psc_val_d = prescale_i;
                end
            end
            StStop: begin
                if (enable_i) begin
                    // Resume mid-period; the period is not restarted.
                    state_d = StRun;
                    if (wrap) begin
                        start_d   = 1'b1;
                        psc_val_d = prescale_i;
                    end
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle) begin
            if (tick) begin
                cnt_d     = cnt_q + 1'b1;
                psc_cnt_d = '0;
            end else begin
                psc_cnt_d = psc_cnt_q + 1'b1;
            end
        end

        ex_rst_n_d = (state_d != StIdle);
        running_d  = (state_d != StIdle);
        pwm_d      = (state_q != StIdle) && (cnt_q < pwm_value_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            psc_cnt_q  <= '0;
            psc_val_q  <= '0;
            start_q    <= 1'b0;
            ex_rst_n_q <= 1'b0;
            running_q  <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            psc_cnt_q  <= psc_cnt_d;
            psc_val_q  <= psc_val_d;
            start_q    <= start_d;
            ex_rst_n_q <= ex_rst_n_d;
            running_q  <= running_d;
            pwm_q      <= pwm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign ex_rst_no        = ex_rst_n_q;
    assign start_o          = start_q;
    assign global_counter_o = cnt_q;
    assign running_o        = running_q;
    assign pwm_o            = pwm_q;

endmodule

// File: tb/tb_ppwm_ctrl.sv
// tb_ppwm_ctrl: self-checking bench for ppwm_ctrl with a 4-bit period counter.
module tb_ppwm_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned IW = 7;
    localparam int unsigned PW = 4;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic [SW-1:0] prescale_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [PW-1:0] wr_addr_i;
    logic [IW-1:0] wr_data_i;
    logic [PW-1:0] pc_i;
    logic [IW-1:0] instr_o;
    logic [CW-1:0] pwm_value_i;
    logic          ex_rst_no;
    logic          start_o;
    logic [CW-1:0] global_counter_o;
    logic          running_o;
    logic          pwm_o;

    ppwm_ctrl #(
        .COUNTER_WIDTH (CW),
        .INSTR_WIDTH   (IW),
        .PC_WIDTH      (PW),
        .PRESCALE_WIDTH(SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .prescale_i      (prescale_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .pc_i            (pc_i),
        .instr_o         (instr_o),
        .pwm_value_i     (pwm_value_i),
        .ex_rst_no       (ex_rst_no),
        .start_o         (start_o),
        .global_counter_o(global_counter_o),
        .running_o       (running_o),
        .pwm_o           (pwm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [PW-1:0] addr;
        logic [IW-1:0] data;
        logic [PW-1:0] pc;
        logic [IW-1:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          start;
        logic          pwm;
        logic          run;
    } exp_t;

    vec_t          vecs [32];
    logic [IW-1:0] instr_sb [$];
    exp_t          run_sb [$];

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input int k, input logic [CW-1:0] c, input logic s, input logic p);
        exp_t e;
        run_sb.push_back('{cnt: c, start: s, pwm: p, run: 1'b1});
        step();
        e = run_sb.pop_front();
        chk($sformatf("cnt k=%0d", k), global_counter_o, e.cnt);
        chk($sformatf("start k=%0d", k), start_o, e.start);
        chk($sformatf("pwm k=%0d", k), pwm_o, e.pwm);
        chk($sformatf("running k=%0d", k), running_o, e.run);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " running"}, running_o, 1'b0);
        chk({tag, " ex_rst_n"}, ex_rst_no, 1'b0);
        chk({tag, " start"}, start_o, 1'b0);
        chk({tag, " cnt"}, global_counter_o, '0);
        chk({tag, " pwm"}, pwm_o, 1'b0);
        chk({tag, " wr_ready"}, wr_ready_o, 1'b1);
    endtask

    initial begin
        int steps;
        int starts;
        int highs;
        int cnt_at5;
        logic stayed;
        logic [IW-1:0] e_instr;

        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{we: 1'b1, addr: PW'(i), data: IW'(i + 1), pc: PW'(i),
                             exp_instr: IW'(i + 1)};
            vecs[i + 16] = '{we: 1'b0, addr: PW'(0), data: IW'(0), pc: PW'(i),
                             exp_instr: IW'(i + 1)};
        end

        rst_n       = 1'b0;
        enable_i    = 1'b0;
        prescale_i  = '0;
        wr_valid_i  = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        pc_i        = '0;
        pwm_value_i = 4'd5;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_idle("post-reset");

        // Reset clears a written memory word.
        wr_valid_i = 1'b1;
        wr_addr_i  = 4'd3;
        wr_data_i  = 7'h25;
        pc_i       = 4'd3;
        step();
        wr_valid_i = 1'b0;
        chk("mem3 written", instr_o, 7'h25);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mem3 after reset", instr_o, 7'h00);
        chk_idle("reset pulse");

        // Program load and readback sweep.
        for (int i = 0; i < 32; i++) begin
            wr_valid_i = vecs[i].we;
            wr_addr_i  = vecs[i].addr;
            wr_data_i  = vecs[i].data;
            pc_i       = vecs[i].pc;
            instr_sb.push_back(vecs[i].exp_instr);
            step();
            e_instr = instr_sb.pop_front();
            chk($sformatf("instr vec %0d", i), instr_o, e_instr);
        end
        wr_valid_i = 1'b0;

        // Start timing, prescale 0, PWM value 5; a write in RUN must be ignored.
        // Enable drops on the cycle of the second wrap: start still issued, then STOP.
        enable_i = 1'b1;
        step();
        chk("start k=0", start_o, 1'b1);
        chk("cnt k=0", global_counter_o, '0);
        chk("ex_rst_n k=0", ex_rst_no, 1'b1);
        chk("running k=0", running_o, 1'b1);
        chk("wr_ready k=0", wr_ready_o, 1'b0);
        chk("pwm k=0", pwm_o, 1'b0);
        for (int k = 1; k < 48; k++) begin
            wr_valid_i = (k == 2);
            wr_addr_i  = 4'd0;
            wr_data_i  = 7'h7f;
            pc_i       = 4'd0;
            enable_i   = (k < 32);
            run_cycle(k, CW'(k % 16), (k % 16) == 0, ((k - 1) % 16) < 5);
        end
        wr_valid_i = 1'b0;
        chk("mem0 unchanged by run write", instr_o, 7'h01);
        step();
        chk_idle("stop at wrap");

        // Drop enable at counter 7: no further start, idle after wrap.
        enable_i = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        chk("cnt before stop", global_counter_o, 4'd7);
        enable_i = 1'b0;
        steps    = 0;
        starts   = 0;
        while (running_o === 1'b1 && steps < 40) begin
            step();
            steps++;
            if (start_o === 1'b1) starts++;
        end
        chk("stop steps to idle", steps, 9);
        chk("stop start pulses", starts, 0);
        chk_idle("after stop");

        // Resume at counter 10: next start only at the wrap.
        enable_i = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("cnt at resume", global_counter_o, 4'd10);
        chk("running in stop", running_o, 1'b1);
        enable_i = 1'b1;
        steps    = 0;
        stayed   = 1'b1;
        while (start_o !== 1'b1 && steps < 40) begin
            step();
            steps++;
            if (running_o !== 1'b1) stayed = 1'b0;
        end
        chk("resume steps to start", steps, 6);
        chk("resume stayed running", stayed, 1'b1);
        chk("resume cnt at start", global_counter_o, '0);

        // Back to idle before the prescale test.
        enable_i = 1'b0;
        steps    = 0;
        while (running_o === 1'b1 && steps < 40) begin
            step();
            steps++;
        end
        chk("idle before prescale", running_o, 1'b0);

        // Prescale 2 for the first period, changed to 0 mid-period.
        prescale_i = 8'd2;
        enable_i   = 1'b1;
        step();
        chk("prescale start", start_o, 1'b1);
        steps   = 0;
        cnt_at5 = -1;
        while (steps < 200) begin
            if (steps == 10) prescale_i = 8'd0;
            step();
            steps++;
            if (steps == 5) cnt_at5 = int'(global_counter_o);
            if (start_o === 1'b1) break;
        end
        chk("cnt at t=5 prescale 2", cnt_at5, 1);
        chk("period with prescale 2", steps, 48);
        steps = 0;
        while (steps < 200) begin
            step();
            steps++;
            if (start_o === 1'b1) break;
        end
        chk("period with prescale 0", steps, 16);

        // PWM value 0 keeps the pin low.
        pwm_value_i = 4'd0;
        highs       = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pwm_o !== 1'b0) highs++;
        end
        chk("pwm value 0 highs", highs, 0);

        // Reset mid-period wins over everything.
        pwm_value_i = 4'd9;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk_idle("mid-run reset");
        pc_i = 4'd5;
        #1;
        chk("mem after mid-run reset", instr_o, 7'h00);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ppwm_ctrl.md
# ppwm_ctrl

Period sequencer and program store for the programmable-PWM execution unit. It owns the instruction memory, generates the global period counter and the per-period start pulse, and holds the execution unit in reset while a program is loaded. It produces the final PWM pin from the execution unit's PWM value. It sits between the host-side configuration interface and one execution-unit instance.

## Interface
Parameters:
- `COUNTER_WIDTH`, 10, width of the global period counter and PWM value
- `INSTR_WIDTH`, 7, instruction word width
- `PC_WIDTH`, 4, program address width; memory depth is 2^PC_WIDTH
- `PRESCALE_WIDTH`, 8, width of the clock prescaler setting

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset; synchronous, active-low
- `enable_i` in 1: run request; level-sensitive
- `prescale_i` in PRESCALE_WIDTH: counter advances every prescale_i+1 cycles
- `wr_valid_i` in 1: program write request
- `wr_ready_o` out 1: write accepted when high together with wr_valid_i
- `wr_addr_i` in PC_WIDTH: program write address
- `wr_data_i` in INSTR_WIDTH: program write data
- `pc_i` in PC_WIDTH: program counter from the execution unit
- `instr_o` out INSTR_WIDTH: instruction at pc_i
- `pwm_value_i` in COUNTER_WIDTH: PWM compare value from the execution unit
- `ex_rst_no` out 1: synchronous active-low reset to the execution unit
- `start_o` out 1: one-cycle period-start pulse to the execution unit
- `global_counter_o` out COUNTER_WIDTH: global period counter
- `running_o` out 1: high in RUN and STOP
- `pwm_o` out 1: PWM pin

## Operation
- FSM states:
  - IDLE (reset state)
  - RUN
  - STOP
- Transitions:
  - IDLE→RUN when enable_i=1.
  - RUN→STOP when enable_i=0.
  - STOP→RUN when enable_i=1; the current period continues without restarting.
  - STOP→IDLE on the counter wrap tick; no start pulse is issued on that tick.
- Reset values, all registered:
  - State IDLE.
  - global_counter_o=0, prescale counter=0.
  - start_o=0, ex_rst_no=0, running_o=0, pwm_o=0.
  - Every memory word = 0.
- Program memory:
  - Writes are accepted only in IDLE (wr_ready_o = state==IDLE).
  - An accepted write updates mem[wr_addr_i] at the clock edge.
  - Writes with wr_valid_i=1 outside IDLE are ignored; they are not queued.
  - instr_o = mem[pc_i], combinational read.
- Execution-unit reset:
  - ex_rst_no is registered: 0 while the next state is IDLE, 1 otherwise.
  - The execution unit therefore restarts from pc 0 on every run.
- Prescaler:
  - prescale_i is sampled into an internal register at each period start (entering RUN and every wrap).
  - Changes mid-period take effect at the next period.
  - A tick occurs when the prescale counter equals the sampled value; the prescale counter then returns to 0.
- Global counter:
  - Increments by 1 on each tick in RUN/STOP.
  - Wraps from 2^COUNTER_WIDTH−1 to 0; the wrap is a tick.
  - Held at 0 in IDLE.
- Start pulse: start_o=1 for exactly one cycle:
  - in the cycle after the IDLE→RUN edge, with counter=0;
  - in the cycle after each wrap in RUN.
- PWM output:
  - pwm_o is registered: 1 iff running and global_counter_o < pwm_value_i (unsigned).
  - pwm_value_i=0 gives a constant 0.
- Simultaneous events:
  - enable_i falling in the same cycle as a wrap: the wrap start pulse is still issued and the state goes to STOP.
  - rst_n low has priority over everything, in any state and at any point of a period.

## Timing
- enable_i sampled high in IDLE at edge N:
  - at N+1: state=RUN, ex_rst_no=1, start_o=1, counter=0;
  - at N+2: start_o=0.
- prescale=P: counter value k holds for P+1 cycles.
  - Full period = (P+1)·2^COUNTER_WIDTH cycles.
  - Consecutive start pulses are exactly one period apart.
- pwm_o lags global_counter_o/pwm_value_i by 1 cycle.
- Write handshake: accepted in the same cycle as wr_valid_i && wr_ready_o; the data is visible on instr_o from the next cycle.
- STOP→IDLE: in the cycle after the wrap tick, ex_rst_no=0, running_o=0, pwm_o=0, counter=0, wr_ready_o=1.

## Test plan
- Reset with memory written:
  - Load mem[3]=7'h25, then pulse rst_n low for 1 cycle.
  - With pc_i=3: instr_o=0, all outputs 0, wr_ready_o=1.
- Program load:
  - Write addr 0..15 with data = addr+1 in IDLE, then sweep pc_i.
  - instr_o matches each word.
  - A write in RUN does not change memory.
- Start timing, COUNTER_WIDTH=4, prescale_i=0, enable_i held high:
  - start_o pulses in the cycle after enable and then every 16 cycles.
  - counter runs 0..15 and wraps.
- Prescale change:
  - prescale_i=2, then changed to 0 mid-period.
  - First period is 48 cycles, next period is 16 cycles.
- PWM, pwm_value_i=5, COUNTER_WIDTH=4:
  - pwm_o high for counter 0..4, delayed 1 cycle; 5/16 duty cycle.
  - pwm_value_i=0 gives pwm_o always 0.
- Stop and resume:
  - Drop enable_i at counter 7: no further start pulse; IDLE after the wrap; ex_rst_no falls.
  - Reassert enable_i at counter 10 instead: RUN resumes with no extra start_o until the wrap.
